// File: rtl/axil_slv_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite slave register file.
// Holds the response codes, the write/read FSM state enums and the
// byte-strobe merge used when a write commits.
package axil_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // Replace only the bytes whose strobe bit is set; the rest keep old_v.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_slv_regfile_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) between the master and this slave.
// The master modport drives requests, the slave modport drives responses.
interface axil_slv_regfile_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/axil_slv_regfile.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit R/W registers exposed flat
// on regs_o, one outstanding write and one outstanding read at a time.
// Optional feature macro: AXIL_SLV_STATS_EN adds read-only counters of OKAY
// writes (index NUM_REGS) and OKAY reads (index NUM_REGS+1).
module axil_slv_regfile
  import axil_slv_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter int          NUM_REGS = 4,
  parameter logic [31:0] RST_VAL  = 32'h0
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESET,
  axil_slv_regfile_if.slave        s_axi,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam int          IDX_W      = ADDR_W - 2;
  localparam logic [31:0] NUM_REGS_W = 32'(NUM_REGS);

  // Register array
  logic [31:0] regs_q [NUM_REGS];

  // Write path state
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  // Read path state
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              aw_hs, w_hs, ar_hs;
  logic              wr_commit;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_idx_ext, rd_idx_ext;
  logic              wr_reg_hit, wr_stat_hit;
  logic [1:0]        wr_resp;
  logic [31:0]       rd_mux;
  logic              rd_hit;

  assign aw_hs = s_axi.awvalid && awready_q;
  assign w_hs  = s_axi.wvalid  && wready_q;
  assign ar_hs = s_axi.arvalid && arready_q;

  // Effective write operands: a handshake this cycle overrides the latched copy,
  // so a write can commit on the same edge the second half arrives.
  assign wr_idx  = aw_hs ? s_axi.awaddr[ADDR_W-1:2] : wr_idx_q;
  assign wr_data = w_hs  ? s_axi.wdata : wdata_q;
  assign wr_strb = w_hs  ? s_axi.wstrb : wstrb_q;

  assign wr_idx_ext = {{(32-IDX_W){1'b0}}, wr_idx};
  assign rd_idx_ext = {{(32-IDX_W){1'b0}}, s_axi.araddr[ADDR_W-1:2]};
  assign wr_reg_hit = wr_idx_ext < NUM_REGS_W;
`ifdef AXIL_SLV_STATS_EN
  assign wr_stat_hit = (wr_idx_ext == NUM_REGS_W) || (wr_idx_ext == NUM_REGS_W + 32'd1);
`else
  assign wr_stat_hit = 1'b0;
`endif
  assign wr_resp = (wr_reg_hit || wr_stat_hit) ? RESP_OKAY : RESP_SLVERR;

  // Write FSM state and handshake registers
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= WR_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wr_idx_q   <= wr_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Write FSM next state: latch AW and W independently, commit when both are in
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_idx_d   = wr_idx;
    wdata_d    = wr_data;
    wstrb_d    = wr_strb;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        awready_d = !aw_done_d;
        wready_d  = !w_done_d;
        if (aw_done_d && w_done_d) begin
          wr_commit  = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_resp;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Register array update on write commit
  // NOTE: the array is reset because every register is visible on regs_o from reset onward.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RST_VAL;
    end else if (wr_commit && wr_reg_hit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_idx_ext == 32'(k)) regs_q[k] <= strb_merge(regs_q[k], wr_data, wr_strb);
      end
    end
  end

`ifdef AXIL_SLV_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q;

  // OKAY-response counters; a counter read returns its pre-increment value
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (wr_commit && (wr_resp == RESP_OKAY)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (ar_hs && rd_hit)                     rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end
`endif

  // Read data mux; reads the pre-write array, so a same-edge write is not visible
  always_comb begin
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx_ext == 32'(k)) begin
        rd_mux = regs_q[k];
        rd_hit = 1'b1;
      end
    end
`ifdef AXIL_SLV_STATS_EN
    if (rd_idx_ext == NUM_REGS_W) begin
      rd_mux = wr_cnt_q;
      rd_hit = 1'b1;
    end
    if (rd_idx_ext == NUM_REGS_W + 32'd1) begin
      rd_mux = rd_cnt_q;
      rd_hit = 1'b1;
    end
`endif
  end

  // Read FSM state and response registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Read FSM next state: register data on AR handshake, hold until RREADY
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d    = rd_mux;
          rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        arready_d = 1'b0;
        if (s_axi.rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[32*k +: 32] = regs_q[k];
  end

  // Protection bits and byte-offset bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_axil_slv_regfile.sv
// Self-checking bench for axil_slv_regfile: table of write/read vectors with
// a response scoreboard, plus hand-written sequences for the multi-cycle
// corner cases (split AW/W, RREADY backpressure, collision, reset mid-response).
// Build with AXIL_SLV_STATS_EN defined to also exercise the counters.
module tb_axil_slv_regfile;

  localparam int          ADDR_W   = 6;
  localparam int          NUM_REGS = 4;
  localparam logic [31:0] RST_VAL  = 32'hCAFE_0000;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;
`ifdef AXIL_SLV_STATS_EN
  localparam logic [1:0]  STAT_WR_RESP = OKAY;
`else
  localparam logic [1:0]  STAT_WR_RESP = SLVERR;
`endif

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;   // write data, or expected read data
    logic [3:0]        strb;
    logic [1:0]        resp;   // expected response
  } vec_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_REGS*32-1:0] regs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_b[$];
  r_exp_t     exp_r[$];
  vec_t       vecs[$];

  axil_slv_regfile_if #(.ADDR_W(ADDR_W)) bus ();

  axil_slv_regfile #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .RST_VAL  (RST_VAL)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus),
    .regs_o       (regs)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop an expectation for every response handshake about to occur
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 32'(bus.bvalid), 32'(0));
        end else begin
          check("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 32'(bus.rvalid), 32'(0));
        end else begin
          r_exp_t e;
          e = exp_r.pop_front();
          check("rresp", 32'(bus.rresp), 32'(e.resp));
          check("rdata", bus.rdata, e.data);
        end
      end
    end
  end

  task automatic wait_b();
    int cyc = 0;
    while (exp_b.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    if (exp_b.size() != 0) begin
      timeout("wait_b");
      exp_b.delete();
    end
  endtask

  task automatic wait_r();
    int cyc = 0;
    while (exp_r.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    if (exp_r.size() != 0) begin
      timeout("wait_r");
      exp_r.delete();
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    logic aw_ok = 1'b0, w_ok = 1'b0, a_hs, d_hs;
    int cyc = 0;
    exp_b.push_back(resp);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    while (!(aw_ok && w_ok) && cyc < 20) begin
      a_hs = bus.awvalid && bus.awready;
      d_hs = bus.wvalid && bus.wready;
      tick();
      if (a_hs) begin aw_ok = 1'b1; bus.awvalid = 1'b0; end
      if (d_hs) begin w_ok  = 1'b1; bus.wvalid  = 1'b0; end
      cyc++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (!(aw_ok && w_ok)) timeout("write_handshake");
    wait_b();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                         input logic [1:0] resp);
    logic ok = 1'b0, hs;
    int cyc = 0;
    exp_r.push_back('{resp: resp, data: data});
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (!ok && cyc < 20) begin
      hs = bus.arvalid && bus.arready;
      tick();
      if (hs) ok = 1'b1;
      cyc++;
    end
    bus.arvalid = 1'b0;
    if (!ok) timeout("read_handshake");
    wait_r();
  endtask

  task automatic wait_ready(input string name, input logic which_ar);
    int cyc = 0;
    while (!(which_ar ? bus.arready : bus.awready) && cyc < 20) begin
      tick();
      cyc++;
    end
    if (cyc >= 20) timeout(name);
  endtask

  task automatic check_regs_rst(input string name);
    for (int k = 0; k < NUM_REGS; k++) check(name, regs[32*k +: 32], RST_VAL);
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    rst = 1'b0;

    // Vectors: {is_wr, addr, data (write data / expected rdata), strb, expected resp}
    vecs.push_back('{1'b1, 6'h00, 32'hAABB_CCDD, 4'hF, OKAY});
    vecs.push_back('{1'b1, 6'h00, 32'h1122_3344, 4'h5, OKAY});
    vecs.push_back('{1'b0, 6'h00, 32'hAA22_CC44, 4'h0, OKAY});
    vecs.push_back('{1'b0, 6'h04, 32'hDEAD_BEEF, 4'h0, OKAY});
    vecs.push_back('{1'b1, 6'h0C, 32'h1234_5678, 4'h0, OKAY});
    vecs.push_back('{1'b0, 6'h0C, 32'hCAFE_0000, 4'h0, OKAY});
    vecs.push_back('{1'b1, 6'h0D, 32'hAB00_0000, 4'h8, OKAY});
    vecs.push_back('{1'b0, 6'h0F, 32'hABFE_0000, 4'h0, OKAY});
    vecs.push_back('{1'b1, 6'h20, 32'hFFFF_FFFF, 4'hF, SLVERR});
    vecs.push_back('{1'b0, 6'h20, 32'h0000_0000, 4'h0, SLVERR});
    vecs.push_back('{1'b1, 6'h10, 32'h5555_5555, 4'hF, STAT_WR_RESP});
    vecs.push_back('{1'b0, 6'h3C, 32'h0000_0000, 4'h0, SLVERR});
    vecs.push_back('{1'b0, 6'h08, 32'hCAFE_0000, 4'h0, OKAY});
    vecs.push_back('{1'b0, 6'h00, 32'hAA22_CC44, 4'h0, OKAY});

    // Reset: outputs quiet, registers at RST_VAL, readies rise one edge after release
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_awready", 32'(bus.awready), 32'(0));
    check("rst_wready",  32'(bus.wready),  32'(0));
    check("rst_arready", 32'(bus.arready), 32'(0));
    check("rst_bvalid",  32'(bus.bvalid),  32'(0));
    check("rst_rvalid",  32'(bus.rvalid),  32'(0));
    check("rst_rdata",   bus.rdata, 32'(0));
    check("rst_resp",    32'({bus.bresp, bus.rresp}), 32'(0));
    check_regs_rst("rst_regs");
    @(negedge clk) rst = 1'b0;
    #1 check("awready_before_edge", 32'(bus.awready), 32'(0));
    tick();
    check("awready_after_rst", 32'(bus.awready), 32'(1));
    check("wready_after_rst",  32'(bus.wready),  32'(1));
    check("arready_after_rst", 32'(bus.arready), 32'(1));

    // AW first, W three cycles later
    bus.awaddr = 6'h04; bus.awvalid = 1'b1; bus.bready = 1'b0;
    wait_ready("aw_split", 1'b0);
    tick();
    bus.awvalid = 1'b0;
    check("aw_latched_awready", 32'(bus.awready), 32'(0));
    check("aw_latched_wready",  32'(bus.wready),  32'(1));
    repeat (3) tick();
    check("no_b_before_w", 32'(bus.bvalid), 32'(0));
    exp_b.push_back(OKAY);
    bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("b_latency", 32'(bus.bvalid), 32'(1));
    check("regs1_after_commit", regs[63:32], 32'hDEAD_BEEF);
    check("wready_in_resp", 32'(bus.wready), 32'(0));
    repeat (2) begin
      tick();
      check("bvalid_hold", 32'(bus.bvalid), 32'(1));
      check("awready_in_resp", 32'(bus.awready), 32'(0));
    end
    bus.bready = 1'b1;
    wait_b();
    check("bvalid_after_b", 32'(bus.bvalid), 32'(0));
    check("awready_after_b", 32'(bus.awready), 32'(1));

    // Table-driven write/read vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
      else               do_read(vecs[i].addr, vecs[i].data, vecs[i].resp);
    end
    check("regs0", regs[31:0],   32'hAA22_CC44);
    check("regs1", regs[63:32],  32'hDEAD_BEEF);
    check("regs2", regs[95:64],  32'hCAFE_0000);
    check("regs3", regs[127:96], 32'hABFE_0000);

    // Read with RREADY held low for four cycles
    bus.rready = 1'b0; bus.araddr = 6'h04; bus.arvalid = 1'b1;
    exp_r.push_back('{resp: OKAY, data: 32'hDEAD_BEEF});
    wait_ready("ar_stall", 1'b1);
    tick();
    bus.arvalid = 1'b0;
    check("r_latency", 32'(bus.rvalid), 32'(1));
    repeat (4) begin
      check("rvalid_hold",  32'(bus.rvalid), 32'(1));
      check("rdata_hold",   bus.rdata, 32'hDEAD_BEEF);
      check("arready_stall", 32'(bus.arready), 32'(0));
      tick();
    end
    bus.rready = 1'b1;
    wait_r();
    check("rvalid_after_r",  32'(bus.rvalid),  32'(0));
    check("arready_after_r", 32'(bus.arready), 32'(1));

    // Write and read to the same register committing on the same edge
    do_write(6'h08, 32'h0000_0001, 4'hF, OKAY);
    check("coll_awready", 32'(bus.awready), 32'(1));
    check("coll_wready",  32'(bus.wready),  32'(1));
    check("coll_arready", 32'(bus.arready), 32'(1));
    exp_b.push_back(OKAY);
    exp_r.push_back('{resp: OKAY, data: 32'h0000_0001});
    bus.awaddr = 6'h08; bus.wdata = 32'h0000_0005; bus.wstrb = 4'hF;
    bus.araddr = 6'h08;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    wait_b();
    wait_r();
    do_read(6'h08, 32'h0000_0005, OKAY);

    // Reset while a write response is pending
    bus.bready = 1'b0;
    bus.awaddr = 6'h04; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("pre_rst_bvalid", 32'(bus.bvalid), 32'(1));
    check("pre_rst_regs1", regs[63:32], 32'h0BAD_F00D);
    #2 rst = 1'b1;
    #1 check("rst_drops_bvalid", 32'(bus.bvalid), 32'(0));
    check("rst_drops_awready", 32'(bus.awready), 32'(0));
    check_regs_rst("rst_mid_regs");
    @(negedge clk) rst = 1'b0;
    bus.bready = 1'b1;
    tick();
    check("awready_after_rst2", 32'(bus.awready), 32'(1));

`ifdef AXIL_SLV_STATS_EN
    // Counters: three OKAY writes, then one plain read and the wr_cnt readback
    do_write(6'h00, 32'h0000_0001, 4'hF, OKAY);
    do_write(6'h04, 32'h0000_0002, 4'hF, OKAY);
    do_write(6'h08, 32'h0000_0003, 4'hF, OKAY);
    do_read(6'h00, 32'h0000_0001, OKAY);
    do_read(6'h10, 32'd3, OKAY);
    do_read(6'h14, 32'd2, OKAY);
`else
    do_read(6'h04, RST_VAL, OKAY);
    do_read(6'h10, 32'h0, SLVERR);
`endif

    repeat (3) tick();
    check("sb_b_empty", 32'(exp_b.size()), 32'(0));
    check("sb_r_empty", 32'(exp_r.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
